palette_lookup_arbiter: RTL and testbench

//  Shared palette store plus round-robin arbiter for the sprite decoders. Holds NUM_PAL

---
 rtl/palette_lookup_arbiter.sv | 147 ++++++++++++++
 tb/tb_palette_lookup_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_lookup_arbiter.sv
// Shared sprite palette store with a round-robin lookup arbiter.
// Writes take priority over lookups; each lookup returns its result one cycle later.
module palette_lookup_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int NUM_PAL = 8,
  parameter  int COLOR_W = 24,
  localparam int PAL_W   = $clog2(NUM_PAL),
  localparam int ID_W    = $clog2(NUM_REQ),
  localparam int ADDR_W  = PAL_W + 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  output logic                     o_ready,
  input  logic                     i_wr_en,
  input  logic [PAL_W-1:0]         i_wr_pal,
  input  logic [3:0]               i_wr_idx,
  input  logic [COLOR_W-1:0]       i_wr_color,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*PAL_W-1:0] i_req_pal,
  input  logic [NUM_REQ*4-1:0]     i_req_idx,
  output logic [NUM_REQ-1:0]       o_gnt,
  output logic                     o_rsp_valid,
  output logic [ID_W-1:0]          o_rsp_id,
  output logic [COLOR_W-1:0]       o_rsp_color,
  output logic                     o_rsp_transp
);

  typedef enum logic {INIT, RUN} state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    init_cnt_q, init_cnt_d;
  logic [ID_W-1:0]      rr_q, rr_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  logic [COLOR_W-1:0]   rsp_color_q, rsp_color_d;
  logic                 rsp_transp_q, rsp_transp_d;

  logic [COLOR_W-1:0]   mem_q [NUM_PAL*16];
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [COLOR_W-1:0]   mem_wdata;

  logic                 gnt_found;
  logic [ID_W-1:0]      gnt_id;
  logic [ID_W:0]        cand;
  logic [NUM_REQ-1:0]   gnt;
  logic [PAL_W-1:0]     sel_pal;
  logic [3:0]           sel_idx;
  logic [COLOR_W-1:0]   rd_color;

  // Scan from the RR pointer upward; a pending write or reset blocks any grant.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    gnt       = '0;
    if (state_q == RUN && i_rst_n && !i_wr_en) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand = {1'b0, rr_q} + (ID_W+1)'(i);
        if (cand >= (ID_W+1)'(NUM_REQ))
          cand = cand - (ID_W+1)'(NUM_REQ);
        if (!gnt_found && i_req[cand[ID_W-1:0]]) begin
          gnt_found = 1'b1;
          gnt_id    = cand[ID_W-1:0];
        end
      end
    end
    if (gnt_found)
      gnt[gnt_id] = 1'b1;
  end

  assign sel_pal  = i_req_pal[gnt_id*PAL_W +: PAL_W];
  assign sel_idx  = i_req_idx[gnt_id*4 +: 4];
  assign rd_color = mem_q[{sel_pal, sel_idx}];

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    rr_d         = rr_q;
    rsp_valid_d  = 1'b0;
    rsp_id_d     = rsp_id_q;
    rsp_color_d  = rsp_color_q;
    rsp_transp_d = rsp_transp_q;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    unique case (state_q)
      INIT: begin
        mem_we     = 1'b1;
        mem_addr   = init_cnt_q;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == '1)
          state_d = RUN;
      end
      RUN: begin
        if (i_wr_en) begin
          mem_we    = 1'b1;
          mem_addr  = {i_wr_pal, i_wr_idx};
          mem_wdata = i_wr_color;
        end else if (gnt_found) begin
          rsp_valid_d  = 1'b1;
          rsp_id_d     = gnt_id;
          rsp_transp_d = (sel_idx == 4'd0);
          rsp_color_d  = (sel_idx == 4'd0) ? '0 : rd_color;
          if (gnt_id == ID_W'(NUM_REQ-1))
            rr_d = '0;
          else
            rr_d = gnt_id + 1'b1;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= INIT;
      init_cnt_q   <= '0;
      rr_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_color_q  <= '0;
      rsp_transp_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      rr_q         <= rr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_color_q  <= rsp_color_d;
      rsp_transp_q <= rsp_transp_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we)
      mem_q[mem_addr] <= mem_wdata;
  end

  assign o_ready      = (state_q == RUN);
  assign o_gnt        = gnt;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_id     = rsp_id_q;
  assign o_rsp_color  = rsp_color_q;
  assign o_rsp_transp = rsp_transp_q;

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Directed bench for palette_lookup_arbiter: init, lookups,
// round-robin, write blocking, transparency and mid-run reset.
module tb_palette_lookup_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ready;
  logic        wr_en;
  logic [2:0]  wr_pal;
  logic [3:0]  wr_idx;
  logic [23:0] wr_color;
  logic [3:0]  req;
  logic [11:0] req_pal;
  logic [15:0] req_idx;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [23:0] rsp_color;
  logic        rsp_transp;

  int checks;
  int errors;

  logic [3:0]  obs_gnt;
  logic        obs_valid;
  logic [1:0]  obs_id;
  logic [23:0] obs_color;
  logic        obs_transp;

  palette_lookup_arbiter dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .o_ready      (ready),
    .i_wr_en      (wr_en),
    .i_wr_pal     (wr_pal),
    .i_wr_idx     (wr_idx),
    .i_wr_color   (wr_color),
    .i_req        (req),
    .i_req_pal    (req_pal),
    .i_req_idx    (req_idx),
    .o_gnt        (gnt),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_id     (rsp_id),
    .o_rsp_color  (rsp_color),
    .o_rsp_transp (rsp_transp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic wr(input int pal, input int idx, input logic [23:0] c);
    @(negedge clk);
    wr_en    = 1'b1;
    wr_pal   = 3'(pal);
    wr_idx   = 4'(idx);
    wr_color = c;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic lookup(input int id, input int pal, input int idx);
    @(negedge clk);
    req = '0;
    req[id] = 1'b1;
    req_pal[id*3 +: 3] = 3'(pal);
    req_idx[id*4 +: 4] = 4'(idx);
    #1 obs_gnt = gnt;
    @(posedge clk);
    #1;
    req        = '0;
    obs_valid  = rsp_valid;
    obs_id     = rsp_id;
    obs_color  = rsp_color;
    obs_transp = rsp_transp;
  endtask

  task automatic test_reset;
    int cnt0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b0 || rsp_valid !== 1'b0 || gnt !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctl ready=%b valid=%b gnt=%b want 0 0 0",
               ready, rsp_valid, gnt);
    end
    checks++;
    if (rsp_id !== 2'd0 || rsp_color !== 24'd0 || rsp_transp !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp id=%0d color=%h transp=%b want 0 0 0",
               rsp_id, rsp_color, rsp_transp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'hF;
    cnt0  = 0;
    for (int k = 0; k < 300; k++) begin
      if (ready === 1'b1) break;
      cnt0++;
      wr_en    = (cnt0 >= 120 && cnt0 < 127);
      wr_pal   = 3'd3;
      wr_idx   = 4'd5;
      wr_color = 24'h123456;
      if (cnt0 >= 100) req = '0;
      if (cnt0 == 50) begin
        #1;
        checks++;
        if (gnt !== 4'b0) begin
          errors++;
          $display("FAIL init_gnt gnt=%b want 0000", gnt);
        end
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
    req   = '0;
    checks++;
    if (cnt0 != 128) begin
      errors++;
      $display("FAIL init_len cycles=%0d want 128", cnt0);
    end
    lookup(0, 3, 5);
    checks++;
    if (obs_gnt !== 4'b0001 || obs_valid !== 1'b1 || obs_id !== 2'd0) begin
      errors++;
      $display("FAIL post_init_ctl gnt=%b valid=%b id=%0d want 0001 1 0",
               obs_gnt, obs_valid, obs_id);
    end
    checks++;
    if (obs_color !== 24'd0 || obs_transp !== 1'b0) begin
      errors++;
      $display("FAIL post_init_data color=%h transp=%b want 000000 0",
               obs_color, obs_transp);
    end
  endtask

  task automatic test_write_read;
    wr(2, 1, 24'hfefe00);
    wr(2, 15, 24'hfd0000);
    lookup(1, 2, 15);
    checks++;
    if (obs_gnt !== 4'b0010 || obs_valid !== 1'b1 || obs_id !== 2'd1 ||
        obs_color !== 24'hfd0000 || obs_transp !== 1'b0) begin
      errors++;
      $display("FAIL wr_rd_15 gnt=%b v=%b id=%0d c=%h t=%b want 0010 1 1 fd0000 0",
               obs_gnt, obs_valid, obs_id, obs_color, obs_transp);
    end
    lookup(2, 2, 1);
    checks++;
    if (obs_gnt !== 4'b0100 || obs_id !== 2'd2 || obs_color !== 24'hfefe00) begin
      errors++;
      $display("FAIL wr_rd_1 gnt=%b id=%0d c=%h want 0100 2 fefe00",
               obs_gnt, obs_id, obs_color);
    end
    lookup(3, 2, 0);
    checks++;
    if (obs_id !== 2'd3 || obs_color !== 24'd0 || obs_transp !== 1'b1) begin
      errors++;
      $display("FAIL wr_rd_0 id=%0d c=%h t=%b want 3 000000 1",
               obs_id, obs_color, obs_transp);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_pulse valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_round_robin;
    logic [23:0] exp_c [4];
    int results;
    exp_c[0] = 24'hfefe00;
    exp_c[1] = 24'hfd0000;
    exp_c[2] = 24'hfefe00;
    exp_c[3] = 24'hfd0000;
    results = 0;
    @(negedge clk);
    req     = 4'hF;
    req_pal = {3'd2, 3'd2, 3'd2, 3'd2};
    req_idx = {4'd15, 4'd1, 4'd15, 4'd1};
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (gnt !== 4'(1 << (k % 4))) begin
        errors++;
        $display("FAIL rr_gnt%0d gnt=%b want %b", k, gnt, 4'(1 << (k % 4)));
      end
      @(posedge clk);
      #1;
      if (rsp_valid === 1'b1) results++;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4) ||
          rsp_color !== exp_c[k % 4]) begin
        errors++;
        $display("FAIL rr_rsp%0d v=%b id=%0d c=%h want 1 %0d %h",
                 k, rsp_valid, rsp_id, rsp_color, k % 4, exp_c[k % 4]);
      end
      if (k == 7) req = '0;
      @(negedge clk);
    end
    checks++;
    if (results != 8) begin
      errors++;
      $display("FAIL rr_count results=%0d want 8", results);
    end
  endtask

  task automatic test_write_block;
    logic [23:0] cols [3];
    cols[0] = 24'h111111;
    cols[1] = 24'h222222;
    cols[2] = 24'h333333;
    @(negedge clk);
    req = 4'b1010;
    req_pal[1*3 +: 3] = 3'd5;
    req_pal[3*3 +: 3] = 3'd5;
    req_idx[1*4 +: 4] = 4'd4;
    req_idx[3*4 +: 4] = 4'd2;
    for (int w = 0; w < 3; w++) begin
      wr_en    = 1'b1;
      wr_pal   = 3'd5;
      wr_idx   = 4'(2 + w);
      wr_color = cols[w];
      #1;
      checks++;
      if (gnt !== 4'b0) begin
        errors++;
        $display("FAIL wb_gnt%0d gnt=%b want 0000", w, gnt);
      end
      @(posedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL wb_valid%0d valid=%b want 0", w, rsp_valid);
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL wb_resume gnt=%b want 0010", gnt);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_color !== 24'h333333) begin
      errors++;
      $display("FAIL wb_rd1 v=%b id=%0d c=%h want 1 1 333333",
               rsp_valid, rsp_id, rsp_color);
    end
    req = 4'b1000;
    @(negedge clk);
    #1;
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL wb_next gnt=%b want 1000", gnt);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_color !== 24'h111111) begin
      errors++;
      $display("FAIL wb_rd3 v=%b id=%0d c=%h want 1 3 111111",
               rsp_valid, rsp_id, rsp_color);
    end
    req = '0;
  endtask

  task automatic test_transparent;
    wr(0, 0, 24'hffa600);
    lookup(2, 0, 0);
    checks++;
    if (obs_gnt !== 4'b0100 || obs_valid !== 1'b1 ||
        obs_transp !== 1'b1 || obs_color !== 24'd0) begin
      errors++;
      $display("FAIL transp gnt=%b v=%b t=%b c=%h want 0100 1 1 000000",
               obs_gnt, obs_valid, obs_transp, obs_color);
    end
    lookup(2, 5, 3);
    checks++;
    if (obs_gnt !== 4'b0100 || obs_transp !== 1'b0 ||
        obs_color !== 24'h222222) begin
      errors++;
      $display("FAIL opaque gnt=%b t=%b c=%h want 0100 0 222222",
               obs_gnt, obs_transp, obs_color);
    end
  endtask

  task automatic test_reset_mid;
    wr(6, 7, 24'habcdef);
    lookup(3, 6, 7);
    checks++;
    if (obs_color !== 24'habcdef) begin
      errors++;
      $display("FAIL pre_rst c=%h want abcdef", obs_color);
    end
    @(negedge clk);
    req = 4'b0001;
    req_pal[0 +: 3] = 3'd6;
    req_idx[0 +: 4] = 4'd7;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    req = '0;
    checks++;
    if (rsp_valid !== 1'b0 || ready !== 1'b0 || rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL mid_rst valid=%b ready=%b id=%0d want 0 0 0",
               rsp_valid, ready, rsp_id);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (ready === 1'b1) break;
      @(negedge clk);
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL reinit_timeout ready=%b want 1", ready);
    end
    lookup(0, 6, 7);
    checks++;
    if (obs_gnt !== 4'b0001 || obs_valid !== 1'b1 || obs_color !== 24'd0) begin
      errors++;
      $display("FAIL cleared_a gnt=%b v=%b c=%h want 0001 1 000000",
               obs_gnt, obs_valid, obs_color);
    end
    lookup(1, 2, 15);
    checks++;
    if (obs_gnt !== 4'b0010 || obs_color !== 24'd0 || obs_transp !== 1'b0) begin
      errors++;
      $display("FAIL cleared_b gnt=%b c=%h t=%b want 0010 000000 0",
               obs_gnt, obs_color, obs_transp);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_pal   = '0;
    wr_idx   = '0;
    wr_color = '0;
    req      = '0;
    req_pal  = '0;
    req_idx  = '0;
    test_reset;
    test_write_read;
    test_round_robin;
    test_write_block;
    test_transparent;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
